// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, FSM states, default widths.
package instruction_fetch_unit_pkg;

    localparam int unsigned DefaultAddrW = 5;
    localparam logic [31:0] Nop = 32'h0000_0000;

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StHalted = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory bus: word address out from the fetch unit, combinational read data back.
interface instruction_fetch_unit_if
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW
);

    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_instruction;

    modport master (
        output imem_address,
        input  imem_instruction
    );

    modport slave (
        input  imem_address,
        output imem_instruction
    );

endinterface

// File: rtl/instruction_fetch_unit_pc.sv
// Program counter register with load, hold and increment controls; load wins over hold.
module program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              hold_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (!hold_i && inc_i) begin
            // Word addressing; wraps naturally at 2^ADDR_W.
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-cycle-latency fetch stage: PC, IF/ID register, RUN/HALTED FSM and delivered-fetch counter.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefaultAddrW,
    parameter int unsigned LAST_ADDR  = 14,
    parameter logic [15:0] COUNT_INIT = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [ADDR_W-1:0]         branch_target,
    instruction_fetch_unit_if.master  imem,
    output logic [31:0]               if_id_instruction,
    output logic [ADDR_W-1:0]         if_id_pc_plus1,
    output logic                      if_id_valid,
    output logic                      halted,
    output logic [15:0]               fetch_count
);

    fetch_state_e      state_d, state_q;
    logic [31:0]       instr_d, instr_q;
    logic [ADDR_W-1:0] pc_plus1_d, pc_plus1_q;
    logic              valid_d, valid_q;
    logic              halted_d, halted_q;
    logic [15:0]       count_d, count_q;

    logic              pc_load, pc_hold, pc_inc;
    logic [ADDR_W-1:0] pc;

    program_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .load_i      (pc_load),
        .load_addr_i (branch_target),
        .hold_i      (pc_hold),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    assign imem.imem_address = pc;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        count_d    = count_q;
        pc_load    = 1'b0;
        pc_hold    = 1'b1;
        pc_inc     = 1'b0;

        if (branch_taken) begin
            // Redirect flushes IF/ID but keeps the stale pc_plus1.
            pc_load  = 1'b1;
            instr_d  = Nop;
            valid_d  = 1'b0;
            state_d  = StRun;
            halted_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                StRun: begin
                    instr_d    = imem.imem_instruction;
                    pc_plus1_d = pc + ADDR_W'(1);
                    valid_d    = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (pc == ADDR_W'(LAST_ADDR)) begin
                        state_d  = StHalted;
                        halted_d = 1'b1;
                    end else begin
                        pc_hold = 1'b0;
                        pc_inc  = 1'b1;
                    end
                end
                StHalted: begin
                    instr_d = Nop;
                    valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            instr_q    <= Nop;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= COUNT_INIT;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    assign if_id_instruction = instr_q;
    assign if_id_pc_plus1    = pc_plus1_q;
    assign if_id_valid       = valid_q;
    assign halted            = halted_q;
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: default instance plus a LAST_ADDR=31 saturation instance.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // DUT A: default parameters
    logic        rst_a = 1'b1, stall_a = 1'b0, br_a = 1'b0;
    logic [4:0]  tgt_a = '0;
    logic [31:0] instr_a;
    logic [4:0]  pc1_a;
    logic        valid_a, halted_a;
    logic [15:0] count_a;

    // DUT B: LAST_ADDR=31, counter preloaded near saturation
    logic        rst_b = 1'b1, stall_b = 1'b0, br_b = 1'b0;
    logic [4:0]  tgt_b = '0;
    logic [31:0] instr_b;
    logic [4:0]  pc1_b;
    logic        valid_b, halted_b;
    logic [15:0] count_b;

    instruction_fetch_unit_if #(.ADDR_W(5)) bus_a ();
    instruction_fetch_unit_if #(.ADDR_W(5)) bus_b ();

    function automatic logic [31:0] rom(input logic [4:0] a);
        if (a <= 5'd2)       return 32'h20010003;
        else if (a <= 5'd5)  return 32'h20020003;
        else if (a == 5'd9)  return 32'h8C41000A;
        else if (a == 5'd14) return 32'h10220014;
        else                 return 32'hE000_0000 | 32'(a);
    endfunction

    always_comb bus_a.imem_instruction = rom(bus_a.imem_address);
    always_comb bus_b.imem_instruction = rom(bus_b.imem_address);

    instruction_fetch_unit #(
        .ADDR_W    (5),
        .LAST_ADDR (14)
    ) dut_a (
        .clk               (clk),
        .rst               (rst_a),
        .stall             (stall_a),
        .branch_taken      (br_a),
        .branch_target     (tgt_a),
        .imem              (bus_a.master),
        .if_id_instruction (instr_a),
        .if_id_pc_plus1    (pc1_a),
        .if_id_valid       (valid_a),
        .halted            (halted_a),
        .fetch_count       (count_a)
    );

    instruction_fetch_unit #(
        .ADDR_W     (5),
        .LAST_ADDR  (31),
        .COUNT_INIT (16'hFFF0)
    ) dut_b (
        .clk               (clk),
        .rst               (rst_b),
        .stall             (stall_b),
        .branch_taken      (br_b),
        .branch_target     (tgt_b),
        .imem              (bus_b.master),
        .if_id_instruction (instr_b),
        .if_id_pc_plus1    (pc1_b),
        .if_id_valid       (valid_b),
        .halted            (halted_b),
        .fetch_count       (count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, ".addr"},   32'(bus_a.imem_address), 32'd0);
        check({tag, ".instr"},  instr_a,                 32'h0);
        check({tag, ".pc1"},    32'(pc1_a),              32'd0);
        check({tag, ".valid"},  32'(valid_a),            32'd0);
        check({tag, ".halted"}, 32'(halted_a),           32'd0);
        check({tag, ".count"},  32'(count_a),            32'd0);
    endtask

    initial begin
        // Reset both instances
        step();
        check_reset_a("rst0");
        rst_a = 1'b0;

        // Three fetches from address 0
        for (int k = 1; k <= 3; k++) begin
            step();
            check("run3.instr", instr_a, 32'h20010003);
            check("run3.pc1",   32'(pc1_a), 32'(k));
            check("run3.valid", 32'(valid_a), 32'd1);
        end
        check("run3.count", 32'(count_a), 32'd3);

        // Advance to PC=6, then stall two cycles
        for (int k = 0; k < 3; k++) step();
        check("pre_stall.addr", 32'(bus_a.imem_address), 32'd6);
        stall_a = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall.addr",  32'(bus_a.imem_address), 32'd6);
            check("stall.instr", instr_a, 32'h20020003);
            check("stall.pc1",   32'(pc1_a), 32'd6);
            check("stall.count", 32'(count_a), 32'd6);
        end
        stall_a = 1'b0;
        step();
        check("resume.instr", instr_a, 32'hE0000006);
        check("resume.pc1",   32'(pc1_a), 32'd7);
        check("resume.count", 32'(count_a), 32'd7);

        // Advance to PC=10, branch to 3 with stall also high
        for (int k = 0; k < 3; k++) step();
        check("pre_br.addr", 32'(bus_a.imem_address), 32'd10);
        br_a = 1'b1; tgt_a = 5'd3; stall_a = 1'b1;
        step();
        br_a = 1'b0; stall_a = 1'b0;
        check("br.addr",  32'(bus_a.imem_address), 32'd3);
        check("br.instr", instr_a, 32'h0);
        check("br.valid", 32'(valid_a), 32'd0);
        check("br.pc1",   32'(pc1_a), 32'd10);
        check("br.count", 32'(count_a), 32'd10);
        step();
        check("br_next.instr", instr_a, 32'h20020003);
        check("br_next.pc1",   32'(pc1_a), 32'd4);
        check("br_next.count", 32'(count_a), 32'd11);

        // Reset mid-stall at PC=7
        for (int k = 0; k < 3; k++) step();
        check("pre_rst.addr", 32'(bus_a.imem_address), 32'd7);
        stall_a = 1'b1;
        step();
        rst_a = 1'b1; br_a = 1'b1; tgt_a = 5'd20;
        step();
        check_reset_a("rst_stall");
        rst_a = 1'b0; stall_a = 1'b0; br_a = 1'b0;
        step();
        check("rst_stall_first.instr", instr_a, 32'h20010003);
        check("rst_stall_first.pc1",   32'(pc1_a), 32'd1);
        check("rst_stall_first.count", 32'(count_a), 32'd1);

        // Free run from reset to halt at address 14
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 14) check("pre_halt.halted", 32'(halted_a), 32'd0);
        end
        check("halt.instr",  instr_a, 32'h10220014);
        check("halt.halted", 32'(halted_a), 32'd1);
        check("halt.count",  32'(count_a), 32'd15);
        check("halt.addr",   32'(bus_a.imem_address), 32'd14);
        check("halt.valid",  32'(valid_a), 32'd1);
        for (int k = 0; k < 2; k++) begin
            step();
            check("halted.valid", 32'(valid_a), 32'd0);
            check("halted.instr", instr_a, 32'h0);
            check("halted.addr",  32'(bus_a.imem_address), 32'd14);
            check("halted.count", 32'(count_a), 32'd15);
        end
        br_a = 1'b1; tgt_a = 5'd9;
        step();
        br_a = 1'b0;
        check("unhalt.addr",   32'(bus_a.imem_address), 32'd9);
        check("unhalt.halted", 32'(halted_a), 32'd0);
        step();
        check("unhalt.instr", instr_a, 32'h8C41000A);
        check("unhalt.pc1",   32'(pc1_a), 32'd10);
        check("unhalt.count", 32'(count_a), 32'd16);

        // Halt again, then reset while halted
        for (int k = 0; k < 5; k++) step();
        check("rehalt.halted", 32'(halted_a), 32'd1);
        rst_a = 1'b1;
        step();
        check_reset_a("rst_halt");
        rst_a = 1'b0;
        step();
        check("rst_halt_first.instr", instr_a, 32'h20010003);

        // DUT B: LAST_ADDR=31, counter saturation and wrap only via redirect
        check("b_rst.count", 32'(count_b), 32'hFFF0);
        rst_b = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 15) check("b_sat.count", 32'(count_b), 32'hFFFF);
            if (k == 31) check("b_pre_halt.halted", 32'(halted_b), 32'd0);
        end
        check("b_halt.halted", 32'(halted_b), 32'd1);
        check("b_halt.instr",  instr_b, 32'hE000001F);
        check("b_halt.pc1",    32'(pc1_b), 32'd0);
        check("b_halt.count",  32'(count_b), 32'hFFFF);
        step();
        check("b_hold.addr", 32'(bus_b.imem_address), 32'd31);
        br_b = 1'b1; tgt_b = 5'd0;
        step();
        br_b = 1'b0;
        check("b_wrap.addr", 32'(bus_b.imem_address), 32'd0);
        step();
        check("b_wrap.instr", instr_b, 32'h20010003);
        check("b_wrap.count", 32'(count_b), 32'hFFFF);
        check("b_wrap.valid", 32'(valid_b), 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The parameter ADDR_W SHALL default to 5 and set the word-address width of the instruction memory.
REQ-002 The parameter LAST_ADDR SHALL default to 14 and give the word address of the final program instruction.
REQ-003 The port clk SHALL be a 1-bit input and the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be a 1-bit input providing synchronous, active-high reset.
REQ-005 The port stall SHALL be a 1-bit input from hazard logic that holds the PC and the IF/ID register.
REQ-006 The port branch_taken SHALL be a 1-bit input from ID that requests a redirect.
REQ-007 The port branch_target SHALL be an ADDR_W-bit input giving the absolute word address of the redirect.
REQ-008 The port imem_address SHALL be an ADDR_W-bit output that drives the instruction memory address.
REQ-009 The port imem_instruction SHALL be a 32-bit input carrying the combinational read data from the instruction memory.
REQ-010 The port if_id_instruction SHALL be a 32-bit output holding the registered instruction for decode.
REQ-011 The port if_id_pc_plus1 SHALL be an ADDR_W-bit output holding the registered value PC+1 of that instruction.
REQ-012 The port if_id_valid SHALL be a 1-bit output that is 1 when the IF/ID register holds a real instruction rather than a bubble.
REQ-013 The port halted SHALL be a 1-bit output that is 1 while the FSM is in HALTED.
REQ-014 The port fetch_count SHALL be a 16-bit output counting instructions delivered into IF/ID.

Function
REQ-015 imem_address SHALL equal the PC register combinationally; fetch latency is one cycle, with the instruction registered into IF/ID on the next edge.
REQ-016 The PC SHALL use word addressing; the normal next PC is PC+1 modulo 2^ADDR_W, so address 31 wraps to 0.
REQ-017 The FSM SHALL have two states: RUN and HALTED.
REQ-018 Per-edge priority SHALL be rst > branch_taken > stall > normal fetch.
REQ-019 On branch_taken, the PC SHALL load branch_target and the IF/ID register SHALL be flushed: instruction 32'h00000000 (NOP), valid 0, and pc_plus1 unchanged. This applies in either state, the next state SHALL be RUN, and stall SHALL be ignored.
REQ-020 On stall without branch_taken, the PC, the IF/ID register, the state and fetch_count SHALL all hold.
REQ-021 On a normal fetch in RUN, the IF/ID register SHALL capture imem_instruction and PC+1, valid SHALL go to 1, fetch_count SHALL increment (saturating at 16'hFFFF), and the PC SHALL advance.
REQ-022 A normal fetch with PC==LAST_ADDR SHALL still deliver that instruction, SHALL leave the PC at LAST_ADDR, and SHALL move the FSM to HALTED.
REQ-023 In HALTED without branch_taken, the PC SHALL hold, the IF/ID register SHALL load a NOP with valid 0, and fetch_count SHALL hold.
REQ-024 halted SHALL be registered and SHALL assert on the edge that enters HALTED.

Reset
REQ-025 When rst is sampled high, the PC SHALL become 0, the state RUN, if_id_instruction 0, if_id_pc_plus1 0, if_id_valid 0, halted 0 and fetch_count 0.
REQ-026 Reset mid-operation SHALL override stall and branch_taken on the same edge, and fetch SHALL restart at address 0 on the following edge.

Structure
REQ-027 A shared definitions file SHALL hold the NOP encoding (32'h0), the RUN/HALTED state encodings and the default ADDR_W.
REQ-028 One sub-module, program_counter, SHALL be instantiated; it holds the PC with load, hold and increment controls, and all FSM, IF/ID and counter logic stays in the top level.

Verification
REQ-029 Bench scenarios SHALL use the project ROM, in which addresses 0–2 hold 32'h20010003, addresses 3–5 hold 32'h20020003, address 9 holds 32'h8C41000A and address 14 holds 32'h10220014.
REQ-030 Reset, release, then run 3 edges -> IF/ID shows 32'h20010003 with pc_plus1 = 1, 2, 3 in turn, valid 1, and fetch_count 3.
REQ-031 Assert stall for 2 cycles at PC=6 -> imem_address stays 6, the IF/ID contents and fetch_count are unchanged, and fetch resumes with address 6 on the following edge.
REQ-032 branch_taken with target 3 at PC=10, stall also high -> next edge gives IF/ID NOP with valid 0 and PC 3, and the edge after gives 32'h20020003 with pc_plus1 4.
REQ-033 Free-run from reset -> address 14 delivers 32'h10220014, halted rises on that edge, fetch_count is 15, and later edges give valid 0 and PC 14; branch_taken to 9 then resumes with 32'h8C41000A.
REQ-034 Assert rst while halted, or mid-stall at PC=7 -> all outputs go to their reset values next edge and the first fetch is 32'h20010003.
REQ-035 Set LAST_ADDR=31 and preload fetch_count near saturation -> PC wraps 31->0 only via redirect, since address 31 halts, and fetch_count sticks at 16'hFFFF.
